// File: rtl/ftb_update_arbiter_if.sv
// Bundle between the FTQ commit path, the BPU lookup port and the FTB SRAM write port.
// Handshakes: an update is accepted in any cycle where i_upd_req and o_upd_finished are both high;
// a lookup owns the SRAM in any cycle where o_pred_gnt is high; an SRAM write completes in the
// cycle where o_sram_wreq and i_sram_wack are both high, and the write request holds until then.
interface ftb_update_arbiter_if #(
  parameter int IDX_W  = 9,
  parameter int ENT_W  = 64,
  parameter int QDEPTH = 4
);
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  logic             i_upd_req;
  logic [IDX_W-1:0] i_upd_idx;
  logic [ENT_W-1:0] i_upd_entry;
  logic             o_upd_finished;

  logic             i_pred_req;
  logic             o_pred_gnt;
  logic             o_pred_stall;

  logic             o_sram_wreq;
  logic [IDX_W-1:0] o_sram_widx;
  logic [ENT_W-1:0] o_sram_wdata;
  logic             i_sram_wack;

  logic [CNT_W-1:0] o_q_cnt;

  modport slave (
    input  i_upd_req, i_upd_idx, i_upd_entry, i_pred_req, i_sram_wack,
    output o_upd_finished, o_pred_gnt, o_pred_stall,
    output o_sram_wreq, o_sram_widx, o_sram_wdata, o_q_cnt
  );

  modport master (
    output i_upd_req, i_upd_idx, i_upd_entry, i_pred_req, i_sram_wack,
    input  o_upd_finished, o_pred_gnt, o_pred_stall,
    input  o_sram_wreq, o_sram_widx, o_sram_wdata, o_q_cnt
  );
endinterface

// File: rtl/ftb_update_arbiter.sv
// Arbitrates the single-port FTB SRAM between BPU lookups and queued FTQ updates,
// preferring lookups but forcing a write after STARVE_LIMIT lost cycles or when the queue fills.
module ftb_update_arbiter #(
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int IDX_W        = 9,
  parameter int ENT_W        = 64
) (
  input  logic                clk,
  input  logic                rst,
  ftb_update_arbiter_if.slave bus,
  output logic                o_dbg_state
);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
  localparam int PL_W  = IDX_W + ENT_W;

  localparam logic [PTR_W:0]  PTR_ONE    = (PTR_W + 1)'(1);
  localparam logic [ST_W-1:0] STARVE_MAX = ST_W'(STARVE_LIMIT);
  localparam logic [ST_W-1:0] STARVE_ONE = ST_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PTR_W:0]  wptr_q, wptr_d;
  logic [PTR_W:0]  rptr_q, rptr_d;
  logic [ST_W-1:0] starve_q, starve_d;
  logic [PL_W-1:0] mem_q [QDEPTH];

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            go_write;
  logic            pred_gnt;
  logic            pred_stall;
  logic            sram_wreq;
  logic [PL_W-1:0] head;

  // MSB of each pointer is the wrap flip bit.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]) &&
                 (wptr_q[PTR_W] != rptr_q[PTR_W]);

  // Full is judged on registered pointers, so a pop this cycle never frees room for a push this cycle.
  assign push = bus.i_upd_req && !full && !rst;
  assign head = mem_q[rptr_q[PTR_W-1:0]];

  always_comb begin
    state_d    = state_q;
    go_write   = 1'b0;
    pred_gnt   = 1'b0;
    pred_stall = 1'b0;
    sram_wreq  = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        go_write   = !empty && (!bus.i_pred_req || (starve_q == STARVE_MAX) || full);
        pred_gnt   = bus.i_pred_req && !go_write;
        pred_stall = bus.i_pred_req && go_write;
        if (go_write) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        sram_wreq  = 1'b1;
        pred_stall = bus.i_pred_req;
        if (bus.i_sram_wack) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // While reset is held nothing is granted, requested or consumed.
    if (rst) begin
      pred_gnt   = 1'b0;
      pred_stall = 1'b0;
      sram_wreq  = 1'b0;
      pop        = 1'b0;
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || go_write) begin
      starve_d = '0;
    end else if ((state_q == IDLE) && pred_gnt && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + STARVE_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      starve_q <= starve_d;
    end
  end

  // Payload storage is left untouched by reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[PTR_W-1:0]] <= {bus.i_upd_idx, bus.i_upd_entry};
    end
  end

  assign bus.o_upd_finished = push;
  assign bus.o_pred_gnt     = pred_gnt;
  assign bus.o_pred_stall   = pred_stall;
  assign bus.o_sram_wreq    = sram_wreq;
  assign bus.o_sram_widx    = head[PL_W-1:ENT_W];
  assign bus.o_sram_wdata   = head[ENT_W-1:0];
  assign bus.o_q_cnt        = wptr_q - rptr_q;
  assign o_dbg_state        = state_q;

  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_wack_in_write: assert property (@(posedge clk) disable iff (rst)
                                    !(bus.i_sram_wack && (state_q != WRITE)));
  a_port_exclusive: assert property (@(posedge clk) disable iff (rst)
                                     !(bus.o_sram_wreq && bus.o_pred_gnt));
endmodule
